batch_ram_sequencer: RTL

//  Address/control sequencer for the batch control-bounded filter memories.

---
 rtl/batch_ram_sequencer.sv | 132 +++++++++++++
 1 files changed

// File: rtl/batch_ram_sequencer.sv
// batch_ram_sequencer: packs samples into a 4-section circular sample RAM and sequences read/result addresses
module batch_ram_sequencer #(
    parameter  int N     = 4,
    parameter  int DEPTH = 220,
    parameter  int DSR   = 1,
    localparam int DS    = (DEPTH + DSR - 1) / DSR,
    localparam int SW    = $clog2(4 * DS),
    localparam int RW    = $clog2(2 * DS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     in,
    input  logic             sample_en,
    output logic             sampleWrite,
    output logic [N*DSR-1:0] sampleDataIn,
    output logic [SW-1:0]    sampleAddrIn,
    output logic [SW-1:0]    sampleAddrOut1,
    output logic [SW-1:0]    sampleAddrOut2,
    output logic [SW-1:0]    sampleAddrOut3,
    output logic             resWriteB,
    output logic [RW-1:0]    resAddrInB,
    output logic [RW-1:0]    resAddrOutB,
    output logic             resWriteF,
    output logic [RW-1:0]    resAddrInF,
    output logic [RW-1:0]    resAddrOutF,
    output logic             batch_start,
    output logic             valid
);
    localparam int CW = (DSR > 1) ? $clog2(DSR) : 1;
    localparam logic [SW-1:0] DS_S = SW'(DS);
    localparam logic [SW-1:0] LAST = SW'(DS - 1);
    localparam logic [RW-1:0] DS_R = RW'(DS);

    typedef struct packed {
        logic             write;
        logic [N*DSR-1:0] data;
        logic [SW-1:0]    addr;
        logic [SW-1:0]    out1;
        logic [SW-1:0]    out2;
        logic [SW-1:0]    out3;
        logic             wb;
        logic [RW-1:0]    inb;
        logic [RW-1:0]    outb;
        logic             wf;
        logic [RW-1:0]    inf;
        logic [RW-1:0]    outf;
        logic             bs;
        logic             valid;
    } out_t;

    out_t          out_q, out_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    sec_q, sec_d, warm_q, warm_d, sm1, sm2;
    logic [SW-1:0] off_q, off_d, rev;
    logic [RW-1:0] bank, nbank;
    logic [N*DSR-1:0] word;
    logic          wc, wrap, warm;

    if (DSR == 1) begin : g_pack
        assign word = in;
    end else begin : g_pack
        logic [N*(DSR-1)-1:0] pack_q;
        assign word = {in, pack_q};
        // older samples of the word being assembled, oldest in the LSBs
        always_ff @(posedge clk) pack_q <= rst ? '0 : sample_en ? word[N*DSR-1:N] : pack_q;
    end

    // next-state for pointers, warm-up and the registered RAM controls
    always_comb begin
        wc     = sample_en && cnt_q == CW'(DSR - 1);
        wrap   = off_q == LAST;
        warm   = warm_q == 2'd3;
        sm1    = sec_q - 2'd1;
        sm2    = sec_q - 2'd2;
        rev    = LAST - off_q;
        bank   = sec_q[0] ? DS_R : '0;
        nbank  = sec_q[0] ? '0 : DS_R;
        cnt_d  = sample_en ? (wc ? '0 : cnt_q + CW'(1)) : cnt_q;
        off_d  = wc ? (wrap ? '0 : off_q + SW'(1)) : off_q;
        sec_d  = (wc && wrap) ? sec_q + 2'd1 : sec_q;
        warm_d = (wc && wrap && !warm) ? warm_q + 2'd1 : warm_q;
        out_d  = out_q;
        out_d.write = wc;
        out_d.bs    = wc && off_q == '0 && warm_q != 2'd0;
        out_d.wb    = wc && warm;
        out_d.wf    = wc && warm;
        out_d.valid = out_q.valid || (wc && warm);
        if (wc) begin
            out_d.data = word;
            out_d.addr = SW'(sec_q) * DS_S + off_q;
            out_d.out1 = SW'(sm1) * DS_S + rev;
            out_d.out2 = SW'(sm2) * DS_S + rev;
            out_d.out3 = SW'(sm2) * DS_S + off_q;
            out_d.inb  = bank + RW'(rev);
            out_d.outb = nbank + RW'(off_q);
            out_d.inf  = bank + RW'(off_q);
            out_d.outf = nbank + RW'(off_q);
        end
    end

    // state and output registers; reset discards any partial word
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            sec_q  <= '0;
            off_q  <= '0;
            warm_q <= '0;
            out_q  <= '0;
        end else begin
            cnt_q  <= cnt_d;
            sec_q  <= sec_d;
            off_q  <= off_d;
            warm_q <= warm_d;
            out_q  <= out_d;
        end
    end

    assign sampleWrite    = out_q.write;
    assign sampleDataIn   = out_q.data;
    assign sampleAddrIn   = out_q.addr;
    assign sampleAddrOut1 = out_q.out1;
    assign sampleAddrOut2 = out_q.out2;
    assign sampleAddrOut3 = out_q.out3;
    assign resWriteB      = out_q.wb;
    assign resAddrInB     = out_q.inb;
    assign resAddrOutB    = out_q.outb;
    assign resWriteF      = out_q.wf;
    assign resAddrInF     = out_q.inf;
    assign resAddrOutF    = out_q.outf;
    assign batch_start    = out_q.bs;
    assign valid          = out_q.valid;
endmodule
